// File: rtl/mips_muldiv_iter.sv
// rtl/mips_muldiv_iter.sv - iterative HI/LO multiply/divide engine (MULT/MULTU/DIV/DIVU, MTHI/MTLO)
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   pause         global pipeline pause, freezes every register while high
//   start, op     launch request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_i, rt_i    multiplicand/dividend and multiplier/divisor
//   hi_wr, lo_wr  MTHI/MTLO strobes with wdata, honoured only when idle
//   hi_o, lo_o    HI and LO architectural registers
//   busy, done    operation in flight; one-cycle pulse in the FIXUP cycle
//
// Optional build macro MULDIV_ZERO_SKIP_EN: a zero operand bypasses the
// iteration loop and finishes in two cycles.
module mips_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pause,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            hi_wr,
    input  logic            lo_wr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, SETUP, ITER, FIXUP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   rs_q;      // raw dividend, returned in HI on divide by zero
    logic [XLEN-1:0]   opnd;      // |multiplicand| or |divisor|, constant during ITER
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0] acc;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        // op[0]=0 selects the signed variants
        a_neg     = ~op[0] & rs_i[XLEN-1];
        b_neg     = ~op[0] & rt_i[XLEN-1];
        a_abs     = a_neg ? -rs_i : rs_i;
        b_abs     = b_neg ? -rt_i : rt_i;
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        // When div_ge holds the true difference is below opnd, so it fits in XLEN bits.
        div_diff  = div_shift[XLEN-1:0] - opnd;
        prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix   = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix   = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            rs_q   <= '0;
            opnd   <= '0;
            acc    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (!pause) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // start wins over a simultaneous MTHI/MTLO
                        is_div <= op[1];
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        rs_q   <= rs_i;
                        opnd   <= op[1] ? b_abs : a_abs;
                        acc    <= {{XLEN{1'b0}}, (op[1] ? a_abs : b_abs)};
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end else begin
                        if (hi_wr) hi_o <= wdata;
                        if (lo_wr) lo_o <= wdata;
                    end
                end
                SETUP: begin
                    cnt <= '0;
`ifdef MULDIV_ZERO_SKIP_EN
                    if (opnd == '0 || acc[XLEN-1:0] == '0) begin
                        acc   <= '0;
                        done  <= 1'b1;
                        state <= FIXUP;
                    end else begin
                        state <= ITER;
                    end
`else
                    state <= ITER;
`endif
                end
                ITER: begin
                    if (is_div) begin
                        if (div_ge)
                            acc <= {div_diff, acc[XLEN-2:0], 1'b1};
                        else
                            acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        done  <= 1'b1;
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (!is_div) begin
                        hi_o <= prod_fix[2*XLEN-1:XLEN];
                        lo_o <= prod_fix[XLEN-1:0];
                    end else if (opnd == '0) begin
                        hi_o <= rs_q;
                        lo_o <= '1;
                    end else begin
                        hi_o <= rem_fix;
                        lo_o <= quo_fix;
                    end
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_iter.sv
// tb/tb_mips_muldiv_iter.sv - directed self-checking bench for mips_muldiv_iter
module tb_mips_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pause = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_i = '0;
    logic [31:0] rt_i = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi_o, lo_o;
    logic        busy, done;

    int nvec = 0;
    int nerr = 0;
    int cyc, dn, pre;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mips_muldiv_iter dut (
        .clk(clk), .rst(rst), .pause(pause), .start(start), .op(op),
        .rs_i(rs_i), .rt_i(rt_i), .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
        .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_i = a; rt_i = b; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Counts cycles after the launch edge until busy drops; bounded.
    task automatic wait_idle(output int c, output int d);
        c = 0; d = 0;
        while (busy === 1'b1 && c < 200) begin
            if (done === 1'b1) d++;
            tick;
            c++;
        end
    endtask

    initial begin
        // reset state
        tick; tick;
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rst = 1'b1;
        tick;

        // start under pause is dropped
        pause = 1'b1;
        launch(MULTU, 32'd3, 32'd3);
        pause = 1'b0;
        tick;
        chk("pause_start_drop", {31'b0, busy}, 32'h0);

        // MTHI, then MTHI+MTLO together
        hi_wr = 1'b1; wdata = 32'hA5A5_A5A5;
        tick;
        hi_wr = 1'b0;
        chk("mthi_hi", hi_o, 32'hA5A5_A5A5);
        chk("mthi_lo", lo_o, 32'h0);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h1234_5678;
        tick;
        hi_wr = 1'b0; lo_wr = 1'b0;
        chk("mtboth_hi", hi_o, 32'h1234_5678);
        chk("mtboth_lo", lo_o, 32'h1234_5678);

        // MULTU FFFFFFFF * 2
        launch(MULTU, 32'hFFFF_FFFF, 32'h2);
        chk("multu_busy_e0", {31'b0, busy}, 32'h1);
        wait_idle(cyc, dn);
        chk("multu_cycles", cyc, 32'd34);
        chk("multu_done_cnt", dn, 32'd1);
        chk("multu_hi", hi_o, 32'h1);
        chk("multu_lo", lo_o, 32'hFFFF_FFFE);

        // MULT -3 * 7
        launch(MULT, -32'sd3, 32'd7);
        wait_idle(cyc, dn);
        chk("mult_cycles", cyc, 32'd34);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFEB);

        // DIV -7 / 2 with MTLO attempted while busy
        launch(DIV, -32'sd7, 32'd2);
        lo_wr = 1'b1; wdata = 32'hDEAD_BEEF;
        tick;
        lo_wr = 1'b0;
        chk("mtlo_busy_lo", lo_o, 32'hFFFF_FFEB);
        wait_idle(cyc, dn);
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);

        // divide by zero, unsigned and signed
        launch(DIVU, 32'd100, 32'd0);
        wait_idle(cyc, dn);
        chk("divu0_lo", lo_o, 32'hFFFF_FFFF);
        chk("divu0_hi", hi_o, 32'd100);
        launch(DIV, -32'sd5, 32'd0);
        wait_idle(cyc, dn);
        chk("div0_lo", lo_o, 32'hFFFF_FFFF);
        chk("div0_hi", hi_o, 32'hFFFF_FFFB);

        // DIV overflow
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc, dn);
        chk("divovf_lo", lo_o, 32'h8000_0000);
        chk("divovf_hi", hi_o, 32'h0);

        // start + MTHI in the same idle cycle: start wins
        op = MULT; rs_i = 32'hFFFF_FFFF; rt_i = 32'hFFFF_FFFF;
        start = 1'b1; hi_wr = 1'b1; wdata = 32'hCAFE_F00D;
        tick;
        start = 1'b0; hi_wr = 1'b0;
        chk("start_wins_hi", hi_o, 32'h0);
        wait_idle(cyc, dn);
        chk("mult_m1_hi", hi_o, 32'h0);
        chk("mult_m1_lo", lo_o, 32'h1);

        // DIVU 1000/7 with a 5-cycle pause mid-ITER and a start while busy
        launch(DIVU, 32'd1000, 32'd7);
        tick; tick; tick;
        op = MULTU; rs_i = 32'd5; rt_i = 32'd5; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (6) tick;
        pause = 1'b1;
        repeat (5) tick;
        chk("pause_busy", {31'b0, busy}, 32'h1);
        pause = 1'b0;
        pre = 15;
        wait_idle(cyc, dn);
        chk("pause_cycles", pre + cyc, 32'd39);
        chk("pause_done_cnt", dn, 32'd1);
        chk("pause_lo", lo_o, 32'd142);
        chk("pause_hi", hi_o, 32'd6);
        tick;
        chk("busy_start_ignored", {31'b0, busy}, 32'h0);

        // reset at counter=10
        launch(MULTU, 32'd7, 32'd9);
        repeat (11) tick;
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_hi", hi_o, 32'h0);
        chk("midrst_lo", lo_o, 32'h0);
        tick;
        rst = 1'b1;
        tick;
        launch(MULTU, 32'd3, 32'd5);
        wait_idle(cyc, dn);
        chk("post_rst_cycles", cyc, 32'd34);
        chk("post_rst_lo", lo_o, 32'd15);
        chk("post_rst_hi", hi_o, 32'd0);

        // zero operand latency
        launch(MULTU, 32'd0, 32'd9);
        wait_idle(cyc, dn);
`ifdef MULDIV_ZERO_SKIP_EN
        chk("zero_cycles", cyc, 32'd2);
`else
        chk("zero_cycles", cyc, 32'd34);
`endif
        chk("zero_done_cnt", dn, 32'd1);
        chk("zero_hi", hi_o, 32'd0);
        chk("zero_lo", lo_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_iter.md
Name: mips_muldiv_iter

Overview:
- Iterative HI/LO multiply/divide engine for the MIPS core; the execution side of the MULT/MULTU/DIV/DIVU instruction class decoded in mips_sys.
- Accepts one operation per start pulse and runs a 32-step shift-add or restoring-divide loop.
- Drives busy so the pipeline interlocks MFHI/MFLO, and completes inside the 35-cycle no-pause window the system guarantees after a mul/div fetch.
- Also services MTHI/MTLO writes.

Parameters:
- XLEN, 32, operand width; the iteration count equals XLEN.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- pause  in  1  global pipeline pause; freezes the engine while high
- start  in  1  single-cycle request to launch an operation
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_i  in  32  multiplicand / dividend
- rt_i  in  32  multiplier / divisor
- hi_wr  in  1  MTHI write strobe
- lo_wr  in  1  MTLO write strobe
- wdata  in  32  MTHI/MTLO data
- hi_o  out  32  HI register
- lo_o  out  32  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse in the FIXUP cycle

Behaviour:
- Reset: async on rst=0. State returns to IDLE. hi_o=0, lo_o=0, busy=0, done=0, counter=0. Reset mid-operation discards the operation.
- States: IDLE, SETUP, ITER, FIXUP.
- IDLE -> SETUP: on start=1 and pause=0. Capture op, rs_i, rt_i. For signed ops, take absolute values and latch the result signs.
- SETUP -> ITER: after one cycle. Counter clears to 0.
- ITER:
  - Performs one step per cycle; counter increments.
  - When counter=XLEN-1, the step completes and the state moves to FIXUP.
  - Multiply: 64-bit shift-add, low bit of the multiplier first.
  - Divide: restoring divide, 1 quotient bit per step.
- FIXUP:
  - done=1.
  - Negate the product or quotient if sign_a^sign_b. Negate the remainder if sign_a.
  - On the exit edge: hi_o = product[63:32] or remainder; lo_o = product[31:0] or quotient. Next state is IDLE.
- Latency: start sampled at edge E0. busy=1 from E0 through E34. done is high in the cycle ending at E34. hi_o/lo_o update at E34. Total is 34 cycles, under the 35-cycle bound.
- busy=1 in SETUP, ITER and FIXUP. start while busy is ignored.
- pause=1: all state, counter and datapath registers hold. done and busy hold their values. A start arriving while pause=1 is dropped.
- Divide by zero: lo_o=32'hFFFF_FFFF, hi_o=rs_i, for both DIV and DIVU. No exception.
- DIV overflow, 32'h8000_0000 / -1: lo_o=32'h8000_0000, hi_o=0.
- MTHI/MTLO:
  - In IDLE with pause=0, hi_wr loads hi_o and lo_wr loads lo_o at the next edge. Both may be written in the same cycle.
  - Ignored while busy.
  - If start and a write arrive in the same IDLE cycle, start wins and the write is dropped.
- All arithmetic is modulo 2^64 internally. There is no saturation.

Optional Feature:
- MULDIV_ZERO_SKIP_EN.
- Defined: in SETUP, if rs_i==0 or rt_i==0, skip ITER and go straight to FIXUP. The result is hi_o=lo_o=0, except divide by zero, which follows the rule above. Total latency is 2 cycles: done in the cycle ending at E2, busy ends at E2.
- Undefined: every operation takes the full 34 cycles.

Test Plan:
- MULTU rs=32'hFFFF_FFFF rt=32'h0000_0002 -> hi_o=1, lo_o=32'hFFFF_FFFE at E34; busy high exactly 34 cycles; done pulses once.
- MULT rs=-3 rt=7 -> hi_o=32'hFFFF_FFFF, lo_o=32'hFFFF_FFEB. DIV rs=-7 rt=2 -> lo_o=32'hFFFF_FFFD, hi_o=32'hFFFF_FFFF.
- DIVU rs=100 rt=0 -> lo_o=32'hFFFF_FFFF, hi_o=100. DIV rs=32'h8000_0000 rt=-1 -> lo_o=32'h8000_0000, hi_o=0.
- DIVU 1000/7 with pause=1 held 5 cycles mid-ITER -> results lo_o=142, hi_o=6 at E39; a start pulse while busy is ignored.
- MTHI wdata=32'hA5A5_A5A5 in IDLE -> hi_o updated next edge. MTLO while busy -> lo_o unchanged. start+hi_wr in the same cycle -> hi_o unchanged.
- Assert rst low at counter=10 -> busy=0, hi_o=lo_o=0 immediately. A new MULTU 3*5 after release -> lo_o=15 after 34 cycles. With MULDIV_ZERO_SKIP_EN, MULTU 0*9 -> done in the cycle ending at E2.
